host_bus_sync: RTL
==================

Name: host_bus_sync

Overview:
Consumes the host CPU bus after the pad layer: asynchronous nCS/nRD/nWR strobes plus address/data from the IOB input latches, which are transparent while nWR is low and hold after it rises. Synchronizes the strobes into the FPGA clock domain and turns each host access into one-cycle register read/write strobes for the internal register file. Drives read data back through the tristate output buffer: registered data plus a T control, 1 = high-Z.

Parameters:
ADDR_WIDTH, 6, width of host address bus and regAddr
DATA_WIDTH, 16, width of host data bus and register data
SYNC_STAGES, 2, flip-flop stages on each strobe synchronizer (min 2)
TIMEOUT_CYCLES, 1024, watchdog limit, used only with HOST_BUS_TIMEOUT_EN

Ports:
clk  in  1  system clock; single clock domain
nReset  in  1  asynchronous, active-low reset
nCS  in  1  host chip select, async, active-low
nRD  in  1  host read strobe, async, active-low
nWR  in  1  host write strobe, async, active-low
busAddr  in  ADDR_WIDTH  address from IOB latches
busDataIn  in  DATA_WIDTH  write data from IOB latches
busDataOut  out  DATA_WIDTH  read data to output buffers
busDataT  out  1  output buffer tristate control, 1 = high-Z
regAddr  out  ADDR_WIDTH  register address for current access
regRead  out  1  one-cycle read request
regReadData  in  DATA_WIDTH  register data, valid the cycle after regRead
regWrite  out  1  one-cycle write commit
regWriteData  out  DATA_WIDTH  data for regWrite
busError  out  1  one-cycle pulse on illegal or aborted access

Behaviour:
- Reset, asserted asynchronously and at any time including mid-access: synchronizer flops to 1 (strobes inactive), state IDLE, busDataT=1, busDataOut=0, regAddr=0, regWriteData=0, regRead=regWrite=busError=0.
- Synchronized signals sCS/sRD/sWR are the last stage of each SYNC_STAGES chain. Each has its previous-cycle value for edge detection. Latency from pad edge to sCS/sRD/sWR is SYNC_STAGES cycles.
- Active access: sCS=0 and exactly one of sRD/sWR =0.
- IDLE:
  - Active read: regAddr<=busAddr, regRead=1 for 1 cycle, go to READ_WAIT.
  - Active write: go to WRITE_HOLD.
  - sCS=0 with sRD=sWR=0: busError=1 for 1 cycle, stay IDLE until both strobes go high, then re-arm.
- READ_WAIT, 1 cycle: busDataOut<=regReadData, busDataT<=0, go to READ_HOLD.
- READ_HOLD: hold busDataOut and busDataT=0 until sRD=1 or sCS=1. Then busDataT<=1 and go to IDLE. busDataOut keeps its value. Changes to busAddr during hold are ignored.
- WRITE_HOLD: wait for sWR rising edge (prev 0, now 1).
  - If sCS still 0 on that cycle: regAddr<=busAddr, regWriteData<=busDataIn, regWrite=1 for exactly 1 cycle (same cycle regAddr/regWriteData update are visible: registered outputs valid together), go to IDLE. The upstream latches hold busAddr/busDataIn stable after nWR rises, so sampling at the detected edge is safe.
  - sCS rising before sWR: abort, no regWrite, busError pulse, go to IDLE.
- Exactly one regRead per host read, and one regWrite per host write, regardless of strobe width.
- Back-to-back accesses need ≥1 IDLE cycle between them. Strobes must be high ≥SYNC_STAGES+1 cycles to be seen.
- regRead and regWrite are never asserted in the same cycle.

Optional Feature:
HOST_BUS_TIMEOUT_EN
- Defined: a counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering READ_HOLD/WRITE_HOLD and increments each cycle in those states. On reaching TIMEOUT_CYCLES: busDataT<=1, no regWrite, busError pulse, go to IDLE. The stuck strobe must then deassert before the next access is accepted.
- Undefined: no counter; the hold states wait indefinitely.

Decomposition:
- Shared package: state enum (IDLE, READ_WAIT, READ_HOLD, WRITE_HOLD, WAIT_RELEASE), default widths, reset constants.
- One sub-module: sync_chain (SYNC_STAGES flops, reset value parameter, 1-bit), instantiated three times.

Test Plan:
- Read: host nCS=0, busAddr=0x12, nRD low 20 cycles, regReadData=0xBEEF → single regRead with regAddr=0x12 at SYNC_STAGES cycles after nRD falls. busDataT=0 and busDataOut=0xBEEF from 2 cycles later until SYNC_STAGES cycles after nRD rises.
- Write: busAddr=0x05, busDataIn=0xA55A, nWR low 10 cycles then high → exactly one regWrite, regAddr=0x05, regWriteData=0xA55A, SYNC_STAGES cycles after the rise. busDataT stays 1.
- Abort: nWR low, nCS rises before nWR → no regWrite, one busError pulse.
- Illegal: nRD and nWR both low with nCS=0 → busError once, no strobes, and no new access until both strobes are released.
- Reset mid-access: nReset low during READ_HOLD → busDataT=1 and busDataOut=0 immediately, without waiting for a clock edge; after release with nRD still low, no spurious regRead until the strobe cycles high then low.
- Timeout (macro on, TIMEOUT_CYCLES=16): nRD held low 100 cycles → busDataT returns to 1 after 16 cycles in READ_HOLD, busError pulses once, no second regRead.

Source files
------------

// File: rtl/host_bus_sync_pkg.sv
// Shared types and constants for the host bus synchronizer slice.
// HOST_BUS_TIMEOUT_EN additionally exposes the default watchdog limit.
package host_bus_sync_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 6;
    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
`ifdef HOST_BUS_TIMEOUT_EN
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
`endif

    // Host strobes are active-low, so the synchronizers idle at 1.
    localparam logic STROBE_IDLE = 1'b1;
    localparam logic BUS_HIGH_Z  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_HOLD,
        WRITE_HOLD,
        WAIT_RELEASE
    } state_e;

endpackage

// File: rtl/host_bus_sync_sync_chain.sv
// Single-bit multi-flop synchronizer with a configurable reset value.
module sync_chain
    import host_bus_sync_pkg::*;
#(
    parameter int   STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VAL = STROBE_IDLE
) (
    input  logic clk,
    input  logic nReset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/host_bus_sync.sv
// Host CPU bus front end: synchronizes async strobes and issues one-cycle register strobes.
// Optional watchdog on the hold states is enabled with HOST_BUS_TIMEOUT_EN.
module host_bus_sync
    import host_bus_sync_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
`ifdef HOST_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  nCS,
    input  logic                  nRD,
    input  logic                  nWR,
    input  logic [ADDR_WIDTH-1:0] busAddr,
    input  logic [DATA_WIDTH-1:0] busDataIn,
    output logic [DATA_WIDTH-1:0] busDataOut,
    output logic                  busDataT,
    output logic [ADDR_WIDTH-1:0] regAddr,
    output logic                  regRead,
    input  logic [DATA_WIDTH-1:0] regReadData,
    output logic                  regWrite,
    output logic [DATA_WIDTH-1:0] regWriteData,
    output logic                  busError
);

    localparam int                REL_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [REL_W-1:0]  REL_MAX = REL_W'(SYNC_STAGES + 1);

    logic sCs, sRd, sWr;
    logic sWrPrev_q;

    state_e                state_q, state_d;
    logic [REL_W-1:0]      releaseCnt_q, releaseCnt_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] busDataOut_q, busDataOut_d;
    logic                  busDataT_q, busDataT_d;
    logic [ADDR_WIDTH-1:0] regAddr_q, regAddr_d;
    logic [DATA_WIDTH-1:0] regWriteData_q, regWriteData_d;
    logic                  regWrite_q, regWrite_d;
    logic                  busError_q, busError_d;
    logic                  readIssue;
    logic                  holdTimeout;

    logic activeRead, activeWrite, illegalAccess, sWrRise;

    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(STROBE_IDLE)) u_syncCs (
        .clk(clk), .nReset(nReset), .d_i(nCS), .q_o(sCs)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(STROBE_IDLE)) u_syncRd (
        .clk(clk), .nReset(nReset), .d_i(nRD), .q_o(sRd)
    );
    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(STROBE_IDLE)) u_syncWr (
        .clk(clk), .nReset(nReset), .d_i(nWR), .q_o(sWr)
    );

    assign activeRead    = !sCs && !sRd &&  sWr;
    assign activeWrite   = !sCs &&  sRd && !sWr;
    assign illegalAccess = !sCs && !sRd && !sWr;
    assign sWrRise       = sWr && !sWrPrev_q;

`ifdef HOST_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
    logic             inHold;

    // The counter sits at zero outside the hold states, so entering one starts it from zero.
    assign inHold      = (state_q == READ_HOLD) || (state_q == WRITE_HOLD);
    assign holdCnt_d   = inHold ? holdCnt_q + 1'b1 : '0;
    assign holdTimeout = inHold && (holdCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            holdCnt_q <= '0;
        end else begin
            holdCnt_q <= holdCnt_d;
        end
    end
`else
    assign holdTimeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q        <= IDLE;
            sWrPrev_q      <= STROBE_IDLE;
            releaseCnt_q   <= '0;
            armed_q        <= 1'b0;
            busDataOut_q   <= '0;
            busDataT_q     <= BUS_HIGH_Z;
            regAddr_q      <= '0;
            regWriteData_q <= '0;
            regWrite_q     <= 1'b0;
            busError_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sWrPrev_q      <= sWr;
            releaseCnt_q   <= releaseCnt_d;
            armed_q        <= armed_d;
            busDataOut_q   <= busDataOut_d;
            busDataT_q     <= busDataT_d;
            regAddr_q      <= regAddr_d;
            regWriteData_q <= regWriteData_d;
            regWrite_q     <= regWrite_d;
            busError_q     <= busError_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        busDataOut_d   = busDataOut_q;
        busDataT_d     = busDataT_q;
        regAddr_d      = regAddr_q;
        regWriteData_d = regWriteData_q;
        regWrite_d     = 1'b0;
        busError_d     = 1'b0;
        readIssue      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (armed_q) begin
                    if (activeRead) begin
                        readIssue = 1'b1;
                        regAddr_d = busAddr;
                        state_d   = READ_WAIT;
                    end else if (activeWrite) begin
                        state_d = WRITE_HOLD;
                    end else if (illegalAccess) begin
                        busError_d = 1'b1;
                        state_d    = WAIT_RELEASE;
                    end
                end
            end
            READ_WAIT: begin
                busDataOut_d = regReadData;
                busDataT_d   = 1'b0;
                state_d      = READ_HOLD;
            end
            READ_HOLD: begin
                if (sRd || sCs) begin
                    busDataT_d = BUS_HIGH_Z;
                    state_d    = IDLE;
                end else if (holdTimeout) begin
                    busDataT_d = BUS_HIGH_Z;
                    busError_d = 1'b1;
                    state_d    = WAIT_RELEASE;
                end
            end
            WRITE_HOLD: begin
                // Address/data latches are stable after nWR rises, so sample on the detected edge.
                if (sWrRise && !sCs) begin
                    regAddr_d      = busAddr;
                    regWriteData_d = busDataIn;
                    regWrite_d     = 1'b1;
                    state_d        = IDLE;
                end else if (sCs) begin
                    busError_d = 1'b1;
                    state_d    = IDLE;
                end else if (holdTimeout) begin
                    busError_d = 1'b1;
                    state_d    = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (sRd && sWr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes must be seen high long enough before the next access; this also hides
        // a strobe that was already low when reset was released.
        if (sRd && sWr) begin
            releaseCnt_d = (releaseCnt_q == REL_MAX) ? REL_MAX : releaseCnt_q + 1'b1;
        end else begin
            releaseCnt_d = '0;
        end

        if (state_q == IDLE && state_d != IDLE) begin
            armed_d = 1'b0;
        end else if (releaseCnt_q == REL_MAX) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    assign regRead      = readIssue;
    assign regAddr      = readIssue ? busAddr : regAddr_q;
    assign regWrite     = regWrite_q;
    assign regWriteData = regWriteData_q;
    assign busDataOut   = busDataOut_q;
    assign busDataT     = busDataT_q;
    assign busError     = busError_q;

endmodule
